// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD..COM, iterative shift-add MUL, registered result.
// Define ALU_FLAGS_EN to add the registered {carry, zero} flags output.
module alu_mc #(
  parameter int DSIZE = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [2:0]       op,
  input  logic [DSIZE-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [1:0]       o_dbg_state
`ifdef ALU_FLAGS_EN
  ,
  output logic [1:0]       flags
`endif
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_COM = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         CNTW     = $clog2(DSIZE);
  localparam logic [CNTW-1:0] LP_LAST  = CNTW'(DSIZE - 1);
  localparam logic [SHW:0]    LP_DSIZE = (SHW + 1)'(DSIZE);

  logic [1:0]       r_state;
  logic [DSIZE-1:0] r_out;
  logic [DSIZE-1:0] r_mcand;
  logic [DSIZE-1:0] r_mplier;
  logic [DSIZE-1:0] r_acc;
  logic [CNTW-1:0]  r_cnt;

  logic             w_accept;
  logic [DSIZE:0]   w_sum;
  logic [DSIZE:0]   w_diff;
  logic [SHW-1:0]   w_amt;
  logic             w_amt_oor;
  logic [DSIZE-1:0] w_res;
  logic             w_carry;
  logic [DSIZE-1:0] w_acc_next;
  logic             w_unused_imm;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer holds its bundle while valid & !ready; out/out_valid never change then.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: in_ready = 1'b1;
      ST_DONE: in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept     = in_valid & in_ready;
  assign out_valid    = (r_state == ST_DONE);
  assign out          = r_out;
  assign o_dbg_state  = r_state;
  assign w_unused_imm = ^imm[DSIZE-1:SHW];

  assign w_sum     = {1'b0, a} + {1'b0, b};
  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_amt     = imm[SHW-1:0];
  assign w_amt_oor = ({1'b0, w_amt} >= LP_DSIZE);

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[DSIZE-1:0];
        w_carry = w_sum[DSIZE];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (a < b).
        w_res   = w_diff[DSIZE-1:0];
        w_carry = w_diff[DSIZE];
      end
      OP_AND: w_res = a & b;
      OP_XOR: w_res = a ^ b;
      OP_SLL: w_res = w_amt_oor ? '0 : (a << w_amt);
      OP_SRL: w_res = w_amt_oor ? '0 : (a >> w_amt);
      OP_COM: w_res = {{(DSIZE-1){1'b0}}, (a <= b)};
      default: w_res = '0;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_out    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      if (op == OP_MUL) begin
        r_mcand  <= a;
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_state  <= ST_MUL;
      end else begin
        r_out   <= w_res;
        r_state <= ST_DONE;
      end
    end else begin
      case (r_state)
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNTW'(1);
          // Last iteration publishes directly so the result lands DSIZE edges after accept.
          if (r_cnt == LP_LAST) begin
            r_out   <= w_acc_next;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        ST_IDLE: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic [1:0] r_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_accept) begin
      if (op != OP_MUL) r_flags <= {w_carry, (w_res == '0)};
    end else if ((r_state == ST_MUL) && (r_cnt == LP_LAST)) begin
      r_flags <= {1'b0, (w_acc_next == '0)};
    end
  end

  assign flags = r_flags;
`endif

endmodule
